// File: rtl/dma_engine_pkg.sv
// Shared constants and state encoding for the device-side DMA engine.
// Default address/length/burst match what the CPU-side DMA manager issues.
package dma_engine_pkg;

  localparam int          DMA_WORD_SIZE = 16;
  localparam logic [15:0] DMA_ADDRESS   = 16'h01f4;
  localparam int          DMA_LENGTH    = 12;
  localparam int          DMA_BURST     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_XFER    = 3'd2,
    ST_GAP     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } dma_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dma_engine_if.sv
// Command, bus-arbitration, device-buffer and memory-write signals of the DMA engine.
// master = the engine itself, slave = manager/memory/device side.
interface dma_engine_if #(
  parameter int WIDTH = 16
);

  logic             cmd_valid;
  logic [WIDTH-1:0] cmd_addr;
  logic             bus_request;
  logic             bus_grant;
  logic             dma_end;
  logic             busy;
  logic [7:0]       dev_rd_idx;
  logic [WIDTH-1:0] dev_rd_data;
  logic             mem_write;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;

  modport master (
    input  cmd_valid, cmd_addr, bus_grant, dev_rd_data, mem_ready,
    output bus_request, dma_end, busy, dev_rd_idx, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output cmd_valid, cmd_addr, bus_grant, dev_rd_data, mem_ready,
    input  bus_request, dma_end, busy, dev_rd_idx, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dma_engine.sv
// Device-side DMA engine: requests the bus and writes LENGTH device-buffer words
// to memory in bursts of BURST, then releases the bus and pulses dma_end.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for cmd_valid; all outputs quiet
// ST_REQ     | bus_request high, waiting for bus_grant
// ST_XFER    | writing words; mem_write follows bus_grant
// ST_GAP     | one idle cycle between bursts (mem_write=0)
// ST_RELEASE | bus_request dropped, waiting for bus_grant to fall
// ST_DONE    | dma_end pulse, back to ST_IDLE
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE,
  parameter int LENGTH    = DMA_LENGTH,
  parameter int BURST     = DMA_BURST
) (
  input logic          clk,
  input logic          reset,
  dma_engine_if.master bus
);

  localparam int unsigned       BW         = cnt_width(BURST);
  localparam logic [7:0]        LAST_IDX   = 8'(LENGTH - 1);
  localparam logic [BW-1:0]     BURST_LAST = BW'(BURST - 1);

  dma_state_e           state_q;
  logic [WORD_SIZE-1:0] base_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [7:0]           idx_q;
  logic [BW-1:0]        burst_q;
  logic                 bus_req_q;
  logic                 busy_q;
  logic                 dma_end_q;
  logic                 wr_en_q;

  logic                 mem_write;
  logic                 accept;
  logic [7:0]           idx_d;
  logic [WORD_SIZE-1:0] addr_d;

  assign mem_write = wr_en_q & bus_req_q & bus.bus_grant;
  assign accept    = mem_write & bus.mem_ready;
  assign idx_d     = idx_q + 8'd1;
  // Address is recomputed from the base so it wraps cleanly modulo 2^WORD_SIZE.
  assign addr_d    = base_q + WORD_SIZE'(idx_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      idx_q     <= '0;
      burst_q   <= '0;
      bus_req_q <= 1'b0;
      busy_q    <= 1'b0;
      dma_end_q <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      dma_end_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            base_q    <= bus.cmd_addr;
            addr_q    <= bus.cmd_addr;
            idx_q     <= '0;
            burst_q   <= '0;
            busy_q    <= 1'b1;
            bus_req_q <= 1'b1;
            state_q   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.bus_grant) begin
            wr_en_q <= 1'b1;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Without an accept (stall or grant loss) address and index simply hold.
          if (accept) begin
            idx_q  <= idx_d;
            addr_q <= addr_d;
            if (idx_q == LAST_IDX) begin
              wr_en_q   <= 1'b0;
              bus_req_q <= 1'b0;
              state_q   <= ST_RELEASE;
            end else if (burst_q == BURST_LAST) begin
              burst_q <= '0;
              wr_en_q <= 1'b0;
              state_q <= ST_GAP;
            end else begin
              burst_q <= burst_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          wr_en_q <= 1'b1;
          state_q <= ST_XFER;
        end
        ST_RELEASE: begin
          if (!bus.bus_grant) begin
            busy_q    <= 1'b0;
            dma_end_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          wr_en_q   <= 1'b0;
          bus_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_request = bus_req_q;
  assign bus.dma_end     = dma_end_q;
  assign bus.busy        = busy_q;
  assign bus.dev_rd_idx  = idx_q;
  assign bus.mem_write   = mem_write;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = bus.dev_rd_data;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: table of transfer scenarios plus
// hand-written back-to-back and reset-abort sequences, checked via a write scoreboard.
module tb_dma_engine;
  import dma_engine_pkg::*;

  localparam int LEN = DMA_LENGTH;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  typedef struct {
    logic [15:0] base;
    int          st_at;
    int          st_len;
    int          dr_at;
    int          dr_len;
    logic [15:0] exp_last;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_engine_if #(.WIDTH(DMA_WORD_SIZE)) bus_if ();

  dma_engine #(
    .WORD_SIZE(DMA_WORD_SIZE),
    .LENGTH   (DMA_LENGTH),
    .BURST    (DMA_BURST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  // Device buffer: word i holds i + 0x100.
  assign bus_if.dev_rd_data = {8'h00, bus_if.dev_rd_idx} + 16'h0100;

  int          errors = 0;
  int          checks = 0;
  sb_t         sb[$];
  int          wr_count = 0;
  int          end_count = 0;
  int          cycle_n = 0;
  int          w_cyc[0:15];
  int          cmd_cyc = 0;
  logic [15:0] last_addr = '0;
  bit          in_txn = 0;
  bit          req_fall_pend = 0;
  bit          req_prev = 0;
  int          stall_at = -1, stall_len = 0, stall_left = 0;
  int          drop_at = -1, drop_len = 0, drop_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycle_n++;

  // Write monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (req_fall_pend) begin
      chk("req_fall_after_last", bus_if.bus_request, 0);
      req_fall_pend = 0;
    end
    if (in_txn && wr_count > 0 && wr_count < LEN)
      chk("req_held", bus_if.bus_request, 1);
    if (bus_if.dma_end) begin
      end_count++;
      chk("end_grant_low", bus_if.bus_grant, 0);
    end
    if (bus_if.mem_write) begin
      chk("wr_gated", bus_if.bus_grant & bus_if.bus_request, 1);
      chk("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        chk("wr_addr", bus_if.mem_addr, sb[0].addr);
        chk("wr_data", bus_if.mem_wdata, sb[0].data);
        if (bus_if.mem_ready) begin
          void'(sb.pop_front());
          if (wr_count < 16) w_cyc[wr_count] = cycle_n;
          wr_count++;
          last_addr = bus_if.mem_addr;
          if (wr_count == LEN) req_fall_pend = 1;
        end
      end
    end
  end

  // One clock; afterwards drive the manager/memory model.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (stall_at >= 0 && wr_count == stall_at) begin
      stall_left = stall_len;
      stall_at   = -1;
    end
    if (drop_at >= 0 && wr_count == drop_at) begin
      drop_left = drop_len;
      drop_at   = -1;
    end
    bus_if.mem_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    // Manager grants one cycle after it sees the request.
    bus_if.bus_grant = req_prev && (drop_left == 0);
    if (drop_left > 0) drop_left--;
    req_prev = bus_if.bus_request;
  endtask

  task automatic start_cmd(input logic [15:0] base);
    for (int i = 0; i < LEN; i++)
      sb.push_back('{addr: base + 16'(i), data: 16'(i) + 16'h0100});
    wr_count = 0;
    in_txn   = 1;
    cmd_cyc  = cycle_n;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = base;
    cyc();
    bus_if.cmd_valid = 1'b0;
    chk("accept_busy", bus_if.busy, 1);
    chk("accept_req", bus_if.bus_request, 1);
  endtask

  task automatic wait_end();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cyc();
      if (bus_if.dma_end) seen = 1;
    end
    chk("dma_end_seen", seen, 1);
  endtask

  task automatic finish_txn(input logic [15:0] exp_last);
    chk("sb_empty", sb.size(), 0);
    chk("write_count", wr_count, LEN);
    chk("last_addr", last_addr, exp_last);
    chk("end_busy", bus_if.busy, 0);
    in_txn = 0;
    cyc();
    chk("end_one_cycle", bus_if.dma_end, 0);
  endtask

  vec_t vecs[5];
  int   end_before;

  initial begin
    vecs[0] = '{DMA_ADDRESS, -1, 0, -1, 0, 16'h01ff};  // basic
    vecs[1] = '{DMA_ADDRESS,  5, 3, -1, 0, 16'h01ff};  // stall on word 5
    vecs[2] = '{DMA_ADDRESS, -1, 0,  3, 2, 16'h01ff};  // grant lost after word 2
    vecs[3] = '{16'hfffa,    -1, 0, -1, 0, 16'h0005};  // address wrap
    vecs[4] = '{16'h0100,     2, 1,  9, 3, 16'h010b};  // stall and grant loss

    reset            = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.bus_grant = 1'b0;
    bus_if.mem_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_req", bus_if.bus_request, 0);
    chk("rst_end", bus_if.dma_end, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_wr", bus_if.mem_write, 0);
    chk("rst_addr", bus_if.mem_addr, 0);
    chk("rst_idx", bus_if.dev_rd_idx, 0);
    reset = 1'b0;
    cyc();

    for (int v = 0; v < 5; v++) begin
      stall_at = vecs[v].st_at;
      stall_len = vecs[v].st_len;
      drop_at = vecs[v].dr_at;
      drop_len = vecs[v].dr_len;
      start_cmd(vecs[v].base);
      wait_end();
      finish_txn(vecs[v].exp_last);
      if (v == 0) begin
        // cmd cycle c, request c+1, grant c+2, first write c+3.
        chk("first_wr_latency", w_cyc[0] - cmd_cyc, 3);
        chk("burst0_back2back", w_cyc[3] - w_cyc[0], 3);
        chk("gap_after_4", w_cyc[4] - w_cyc[3], 2);
        chk("gap_after_8", w_cyc[8] - w_cyc[7], 2);
        chk("burst2_back2back", w_cyc[11] - w_cyc[8], 3);
      end
      repeat (2) cyc();
    end

    // Command during XFER is ignored; command in dma_end cycle is ignored; next one accepted.
    start_cmd(16'h0300);
    for (int i = 0; i < 100 && wr_count < 6; i++) cyc();
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = 16'h3000;
    cyc();
    bus_if.cmd_valid = 1'b0;
    wait_end();
    chk("b2b_sb_empty", sb.size(), 0);
    chk("b2b_write_count", wr_count, LEN);
    chk("b2b_last_addr", last_addr, 16'h030b);
    in_txn = 0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_addr  = 16'h4000;
    cyc();
    bus_if.cmd_valid = 1'b0;
    chk("end_cycle_cmd_busy", bus_if.busy, 0);
    chk("end_cycle_cmd_req", bus_if.bus_request, 0);
    chk("end_pulse_single", bus_if.dma_end, 0);
    start_cmd(16'h0600);
    wait_end();
    finish_txn(16'h060b);
    repeat (2) cyc();

    // Reset after word 6 aborts without dma_end; a fresh command then completes.
    start_cmd(16'h0500);
    for (int i = 0; i < 100 && wr_count < 7; i++) cyc();
    chk("abort_progress", wr_count, 7);
    in_txn     = 0;
    end_before = end_count;
    reset      = 1'b1;
    cyc();
    chk("abort_req", bus_if.bus_request, 0);
    chk("abort_wr", bus_if.mem_write, 0);
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_end", bus_if.dma_end, 0);
    reset = 1'b0;
    sb.delete();
    repeat (6) cyc();
    chk("no_end_after_abort", end_count, end_before);
    start_cmd(16'h0700);
    wait_end();
    finish_txn(16'h070b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
